// File: rtl/pipelined_cla.sv
// Pipelined carry-lookahead adder with optional lower-part-OR approximation.
//
// The BITWIDTH-bit add is split into GROUP-bit lookahead groups; every
// GROUPS_PER_STAGE groups form one pipeline stage, and the carry is registered
// between stages. Each stage carries a valid bit and stalls only when it is
// full and the stage after it is not ready, so bubbles collapse.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset; clears valids and all data
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   a, b       unsigned operands
//   cin        carry-in (ignored in approximate mode)
//   approx_en  per-operation approximate mode (low APPROX_LSBS bits = a | b)
//   out_valid  sum valid
//   out_ready  downstream accepts sum
//   sum        BITWIDTH+1 result, MSB is carry-out; 0 whenever out_valid is 0
module pipelined_cla #(
  parameter int unsigned BITWIDTH         = 16,
  parameter int unsigned GROUP            = 4,
  parameter int unsigned GROUPS_PER_STAGE = 2,
  parameter int unsigned APPROX_LSBS      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic                cin,
  input  logic                approx_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH:0]   sum
);

  localparam int unsigned NGROUPS = BITWIDTH / GROUP;
  localparam int unsigned STAGES  = (NGROUPS + GROUPS_PER_STAGE - 1) / GROUPS_PER_STAGE;

  if (BITWIDTH % GROUP != 0) begin : g_bad_width
    $error("BITWIDTH must be a multiple of GROUP");
  end
  if (APPROX_LSBS >= BITWIDTH) begin : g_bad_approx
    $error("APPROX_LSBS must be below BITWIDTH");
  end

  // Per-stage state
  logic [STAGES-1:0]   valid_q, valid_d;
  logic [STAGES-1:0]   approx_q, approx_d;
  logic [STAGES-1:0]   carry_q, carry_d;
  logic [BITWIDTH-1:0] a_q    [STAGES];
  logic [BITWIDTH-1:0] a_d    [STAGES];
  logic [BITWIDTH-1:0] b_q    [STAGES];
  logic [BITWIDTH-1:0] b_d    [STAGES];
  logic [BITWIDTH-1:0] psum_q [STAGES];
  logic [BITWIDTH-1:0] psum_d [STAGES];

  // Stage inputs: index 0 is the port side, index k is the output of stage k-1
  logic [STAGES-1:0]   st_v, st_x, st_c;
  logic [BITWIDTH-1:0] st_a [STAGES];
  logic [BITWIDTH-1:0] st_b [STAGES];
  logic [BITWIDTH-1:0] st_s [STAGES];

  assign st_v[0] = in_valid;
  assign st_x[0] = approx_en;
  assign st_c[0] = cin;
  assign st_a[0] = a;
  assign st_b[0] = b;
  assign st_s[0] = '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign st_v[k] = valid_q[k-1];
    assign st_x[k] = approx_q[k-1];
    assign st_c[k] = carry_q[k-1];
    assign st_a[k] = a_q[k-1];
    assign st_b[k] = b_q[k-1];
    assign st_s[k] = psum_q[k-1];
  end

  // ready[k]: stage k may load this cycle; ready[STAGES] is the downstream.
  logic [STAGES:0] ready;

  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  // Stage arithmetic
  logic [BITWIDTH-1:0] s;
  logic                c;
  logic [GROUP-1:0]    g, p, xb;
  logic [GROUP:0]      cc;
  logic                t, term;
  int unsigned         bit_idx;

  always_comb begin
    s       = '0;
    c       = 1'b0;
    g       = '0;
    p       = '0;
    xb      = '0;
    cc      = '0;
    t       = 1'b0;
    term    = 1'b0;
    bit_idx = 0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      s = st_s[k];
      c = st_c[k];
      for (int unsigned gi = 0; gi < NGROUPS; gi++) begin
        if (gi / GROUPS_PER_STAGE == k) begin
          // Approximate bits kill propagate so cin cannot leak past them;
          // only the top approximate bit generates (a & b) into bit APPROX_LSBS.
          for (int unsigned j = 0; j < GROUP; j++) begin
            bit_idx = gi * GROUP + j;
            xb[j]   = st_x[k] && (bit_idx < APPROX_LSBS);
            if (xb[j]) begin
              g[j] = (bit_idx == APPROX_LSBS - 1) && st_a[k][bit_idx] && st_b[k][bit_idx];
              p[j] = 1'b0;
            end else begin
              g[j] = st_a[k][bit_idx] & st_b[k][bit_idx];
              p[j] = st_a[k][bit_idx] ^ st_b[k][bit_idx];
            end
          end
          // Flat lookahead: cc[j] = c*P[j-1:0] | sum over m of g[m]*P[j-1:m+1]
          cc[0] = c;
          for (int unsigned j = 1; j <= GROUP; j++) begin
            t = c;
            for (int unsigned m = 0; m < j; m++) begin
              t = t & p[m];
            end
            for (int unsigned m = 0; m < j; m++) begin
              term = g[m];
              for (int unsigned n = m + 1; n < j; n++) begin
                term = term & p[n];
              end
              t = t | term;
            end
            cc[j] = t;
          end
          for (int unsigned j = 0; j < GROUP; j++) begin
            bit_idx = gi * GROUP + j;
            if (xb[j]) begin
              s[bit_idx] = st_a[k][bit_idx] | st_b[k][bit_idx];
            end else begin
              s[bit_idx] = p[j] ^ cc[j];
            end
          end
          c = cc[GROUP];
        end
      end

      // Next state: hold on stall, clear on bubble so idle data reads as zero
      valid_d[k]  = valid_q[k];
      approx_d[k] = approx_q[k];
      carry_d[k]  = carry_q[k];
      a_d[k]      = a_q[k];
      b_d[k]      = b_q[k];
      psum_d[k]   = psum_q[k];
      if (ready[k]) begin
        valid_d[k] = st_v[k];
        if (st_v[k]) begin
          approx_d[k] = st_x[k];
          carry_d[k]  = c;
          a_d[k]      = st_a[k];
          b_d[k]      = st_b[k];
          psum_d[k]   = s;
        end else begin
          approx_d[k] = 1'b0;
          carry_d[k]  = 1'b0;
          a_d[k]      = '0;
          b_d[k]      = '0;
          psum_d[k]   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      approx_q <= '0;
      carry_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        psum_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      approx_q <= approx_d;
      carry_q  <= carry_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        psum_q[k] <= psum_d[k];
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = {carry_q[STAGES-1], psum_q[STAGES-1]};

  // Operands and mode of the last stage have no consumer
  logic unused_last;
  assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], approx_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_cla.sv
// Scoreboard bench for pipelined_cla (16-bit, 4-bit groups, 2 groups/stage,
// 4 approximate LSBs -> 2 stages). Driver pushes hand-computed sums, the
// monitor pops and compares at every output transfer.
module tb_pipelined_cla;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin, approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  pipelined_cla #(
    .BITWIDTH        (16),
    .GROUP           (4),
    .GROUPS_PER_STAGE(2),
    .APPROX_LSBS     (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic vx, input logic [16:0] exp, output int waits);
    a         = va;
    b         = vb;
    cin       = vc;
    approx_en = vx;
    in_valid  = 1'b1;
    waits     = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 50);
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    logic        hold_v = 1'b0;
    logic [16:0] hold_sum = '0;
    logic [16:0] e;
    int          n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_sum", 32'(sum), 32'(hold_sum));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got 0x%05h expected none", sum);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("result%0d", n), 32'(sum), 32'(e));
            n++;
          end
        end else if (!out_valid) begin
          check("idle_sum_zero", 32'(sum), 32'd0);
        end
        hold_v   = out_valid && !out_ready;
        hold_sum = sum;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w3;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; approx_en = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Carry across the stage boundary, with latency check
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(out_valid), 32'd1);
    drain("drain_first");
    @(posedge clk); #1;

    send(16'h00FF, 16'h0001, 1'b1, 1'b0, 17'h00101, w);
    send(16'h0008, 16'h0008, 1'b0, 1'b1, 17'h00018, w);
    send(16'h0008, 16'h0008, 1'b0, 1'b0, 17'h00010, w);
    send(16'h000F, 16'h0001, 1'b1, 1'b1, 17'h0000F, w);
    in_valid = 1'b0;
    drain("drain_directed");
    @(posedge clk); #1;

    // Streaming with alternating mode
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, w); check("stream_ready0", 32'(w), 32'd1);
    send(16'h00F8, 16'h0F08, 1'b1, 1'b1, 17'h01008, w); check("stream_ready1", 32'(w), 32'd1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, w); check("stream_ready2", 32'(w), 32'd1);
    send(16'h8007, 16'h8009, 1'b0, 1'b1, 17'h1000F, w); check("stream_ready3", 32'(w), 32'd1);
    send(16'hABCD, 16'h1111, 1'b0, 1'b0, 17'h0BCDE, w); check("stream_ready4", 32'(w), 32'd1);
    send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 17'h07FFF, w); check("stream_ready5", 32'(w), 32'd1);
    send(16'h8000, 16'h8000, 1'b1, 1'b0, 17'h10001, w); check("stream_ready6", 32'(w), 32'd1);
    send(16'h0F0F, 16'h00F8, 1'b0, 1'b1, 17'h0100F, w); check("stream_ready7", 32'(w), 32'd1);
    in_valid = 1'b0;
    drain("drain_stream");
    @(posedge clk); #1;

    // Backpressure: out_ready low for 5 cycles while streaming
    w3 = 0;
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 17'h00003, w);
        send(16'h0100, 16'h0200, 1'b1, 1'b0, 17'h00301, w);
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 17'h03333, w3);
        send(16'hF000, 16'h1000, 1'b0, 1'b0, 17'h10000, w);
        send(16'h0003, 16'h0004, 1'b1, 1'b1, 17'h00007, w);
        in_valid = 1'b0;
      end
    join
    check("bp_in_ready_fell", 32'(w3 > 1), 32'd1);
    drain("drain_backpressure");
    @(posedge clk); #1;

    // Bubbles collapse while stalled
    out_ready = 1'b0;
    send(16'h0042, 16'h0018, 1'b0, 1'b0, 17'h0005A, w);
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(16'h1000, 16'h0FFF, 1'b1, 1'b0, 17'h02000, w);
    check("bubble_collapse", 32'(w), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_bubbles");
    @(posedge clk); #1;

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 17'h02345, w);
    send(16'h2222, 16'h3333, 1'b0, 1'b0, 17'h05555, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_sum", 32'(sum), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 17'h01010, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_reset_lat2", 32'(out_valid), 32'd1);
    drain("drain_post_reset");
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
